// File: rtl/ws2812_driver.sv
`timescale 1ns/1ps
// ws2812_driver: serialises one 24-bit colour as GRB to NUM_LEDS WS2812 LEDs,
// followed by a low latch gap; ocupado covers the whole frame including the gap.
module ws2812_driver #(
  parameter int NUM_LEDS     = 8,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int T_BIT        = 63,
  parameter int RESET_CYCLES = 3000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        iniciar,
  input  logic [23:0] cor_led,
  output logic        ocupado,
  output logic        pronto,
  output logic        dado_led
);
  localparam int CW = T_BIT > 1 ? $clog2(T_BIT) : 1;
  localparam int LW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
  localparam int RW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;

  if (!(0 < T0H && T0H < T1H && T1H < T_BIT) || NUM_LEDS < 1 || RESET_CYCLES < 1) begin : g_bad_params
    $error("ws2812_driver: illegal timing or size parameters");
  end

  typedef enum logic [1:0] {OCIOSO, ENVIA_BIT, LATCH} state_t;

  state_t          r_state, w_next;
  logic [23:0]     r_grb;
  logic [4:0]      r_bit, w_bit_nx;
  logic [LW-1:0]   r_led;
  logic [CW-1:0]   r_cnt, w_cnt_nx, w_thi;
  logic [RW-1:0]   r_lat;
  logic            r_dado, r_ocupado, r_pronto;
  logic            w_dado, w_ocupado, w_pronto;
  logic            w_fim_bit, w_ult, w_lat_fim;

  assign dado_led = r_dado;
  assign ocupado  = r_ocupado;
  assign pronto   = r_pronto;

  // Line level is computed for the count/bit the next cycle will show, so the
  // registered output lines up with the registered counters.
  always_comb begin
    w_fim_bit = r_cnt == CW'(T_BIT - 1);
    w_ult     = r_bit == 5'd0 && r_led == LW'(NUM_LEDS - 1);
    w_cnt_nx  = w_fim_bit ? '0 : r_cnt + CW'(1);
    w_bit_nx  = !w_fim_bit ? r_bit : (r_bit == 5'd0 ? 5'd23 : r_bit - 5'd1);
    w_thi     = r_grb[w_bit_nx] ? CW'(T1H) : CW'(T0H);
    w_lat_fim = r_lat == RW'(RESET_CYCLES - 1);
    w_next    = r_state;
    w_dado    = 1'b0;
    w_ocupado = r_ocupado;
    w_pronto  = 1'b0;
    case (r_state)
      OCIOSO: if (iniciar) begin
        w_next    = ENVIA_BIT;
        w_dado    = 1'b1;
        w_ocupado = 1'b1;
      end
      ENVIA_BIT: if (w_fim_bit && w_ult) w_next = LATCH;
                 else w_dado = w_cnt_nx < w_thi;
      LATCH: if (w_lat_fim) begin
        w_next    = OCIOSO;
        w_ocupado = 1'b0;
        w_pronto  = 1'b1;
      end
      default: w_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= OCIOSO;
      r_grb     <= '0;
      r_bit     <= '0;
      r_led     <= '0;
      r_cnt     <= '0;
      r_lat     <= '0;
      r_dado    <= 1'b0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_dado    <= w_dado;
      r_ocupado <= w_ocupado;
      r_pronto  <= w_pronto;
      r_lat     <= (r_state == LATCH && !w_lat_fim) ? r_lat + RW'(1) : '0;
      if (r_state == OCIOSO && iniciar) begin
        r_grb <= {cor_led[15:8], cor_led[23:16], cor_led[7:0]};
        r_bit <= 5'd23;
        r_led <= '0;
        r_cnt <= '0;
      end else if (r_state == ENVIA_BIT) begin
        r_cnt <= w_cnt_nx;
        r_bit <= w_bit_nx;
        if (w_fim_bit && r_bit == 5'd0 && !w_ult) r_led <= r_led + LW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ws2812_driver.sv
`timescale 1ns/1ps
// tb_ws2812_driver: scoreboard bench; stimulus queues expected high times and
// frame lengths, a negedge monitor measures the line and pops/compares.
module tb_ws2812_driver;
  localparam int N = 2, T0H = 2, T1H = 4, TB = 6, RC = 10;
  localparam int FRAME = N * 24 * TB + RC;

  logic        clock = 1'b0, reset_n = 1'b0, iniciar = 1'b0;
  logic [23:0] cor_led = '0;
  logic        ocupado, pronto, dado_led;

  int tests = 0, fails = 0;
  int q_hi[$], q_frame[$];
  int run = 0, occ_n = 0;
  logic prev_pronto = 1'b0;

  ws2812_driver #(.NUM_LEDS(N), .T0H(T0H), .T1H(T1H), .T_BIT(TB), .RESET_CYCLES(RC)) dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .cor_led(cor_led),
    .ocupado(ocupado), .pronto(pronto), .dado_led(dado_led));

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [23:0] c);
    logic [23:0] g;
    g = {c[15:8], c[23:16], c[7:0]};
    for (int l = 0; l < N; l++)
      for (int b = 23; b >= 0; b--) q_hi.push_back(g[b] ? T1H : T0H);
    q_frame.push_back(FRAME);
  endtask

  task automatic wait_pronto(input string name);
    int k;
    for (k = 0; k < 2 * FRAME; k++) begin
      @(negedge clock);
      if (pronto) break;
    end
    if (k == 2 * FRAME) chk({name, "_timeout"}, 0, 1);
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      run = 0; occ_n = 0; prev_pronto = 1'b0;
    end else begin
      if (ocupado) begin
        occ_n++;
        if (occ_n > N * 24 * TB) chk("latch_low", int'(dado_led), 0);
      end
      if (dado_led) run++;
      else if (run > 0) begin
        if (q_hi.size() == 0) chk("unexpected_pulse", run, 0);
        else chk("high_cycles", run, q_hi.pop_front());
        run = 0;
      end
      if (pronto) begin
        if (q_frame.size() == 0) chk("unexpected_pronto", 1, 0);
        else chk("ocupado_len", occ_n, q_frame.pop_front());
        chk("pronto_ocupado_low", int'(ocupado), 0);
        chk("pronto_one_cycle", int'(prev_pronto), 0);
        occ_n = 0;
      end
      prev_pronto = pronto;
    end
  end

  task automatic pulse_start(input logic [23:0] c);
    @(negedge clock);
    cor_led = c;
    push_frame(c);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clock);
    chk("rst_dado", int'(dado_led), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_pronto", int'(pronto), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_dado", int'(dado_led), 0);

    pulse_start(24'hFF0000);
    chk("start_dado", int'(dado_led), 1);
    chk("start_ocupado", int'(ocupado), 1);
    wait_pronto("single");

    pulse_start(24'h010080);
    wait_pronto("order");

    pulse_start(24'h00FF00);
    repeat (18) @(negedge clock);
    cor_led = 24'h0000FF;
    wait_pronto("colour_change");

    // back-to-back: frame 2 captures the colour present at its own start
    @(negedge clock);
    cor_led = 24'hA5C3F0;
    push_frame(24'hA5C3F0);
    iniciar = 1'b1;
    repeat (30) @(negedge clock);
    cor_led = 24'h3C0FF1;
    push_frame(24'h3C0FF1);
    wait_pronto("b2b_first");
    @(negedge clock);
    chk("b2b_restart_dado", int'(dado_led), 1);
    chk("b2b_restart_ocupado", int'(ocupado), 1);
    iniciar = 1'b0;
    wait_pronto("b2b_second");

    pulse_start(24'h123456);
    for (int i = 0; i < 4; i++) begin
      repeat (40) @(negedge clock);
      iniciar = 1'b1;
      cor_led = 24'hFFFFFF;
      @(negedge clock);
      iniciar = 1'b0;
    end
    wait_pronto("ignored_start");
    repeat (5) @(negedge clock);
    chk("no_extra_frame", int'(ocupado), 0);

    pulse_start(24'hFF0000);
    repeat (61) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_dado", int'(dado_led), 0);
    chk("async_rst_ocupado", int'(ocupado), 0);
    chk("async_rst_pronto", int'(pronto), 0);
    q_hi.delete();
    q_frame.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clock);
      if (dado_led || ocupado || pronto) bad++;
    end
    chk("post_rst_quiet", bad, 0);

    pulse_start(24'h00FF00);
    wait_pronto("post_rst_frame");
    repeat (3) @(negedge clock);
    chk("q_hi_empty", q_hi.size(), 0);
    chk("q_frame_empty", q_frame.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
